// File: rtl/buffering_tx_if.sv
// Device-response and host AXI Stream signals for buffering_tx.
// slave is the block side; master is the device/host side.
interface buffering_tx_if #(
  parameter int CNT_W = 4
) ();
  logic             dev_valid_i;
  logic [18:0]      dev_addr_i;
  logic [15:0]      dev_data_i;
  logic             dev_ready_o;
  logic             rsp_tvalid_o;
  logic [2:0]       rsp_tid_o;
  logic [15:0]      rsp_tdata_o;
  logic             rsp_tlast_o;
  logic             rsp_tready_i;
  logic             host_hold_i;
  logic [CNT_W-1:0] fifo_count_o;

  modport slave (
    input  dev_valid_i,
    input  dev_addr_i,
    input  dev_data_i,
    output dev_ready_o,
    output rsp_tvalid_o,
    output rsp_tid_o,
    output rsp_tdata_o,
    output rsp_tlast_o,
    input  rsp_tready_i,
    input  host_hold_i,
    output fifo_count_o
  );

  modport master (
    output dev_valid_i,
    output dev_addr_i,
    output dev_data_i,
    input  dev_ready_o,
    input  rsp_tvalid_o,
    input  rsp_tid_o,
    input  rsp_tdata_o,
    input  rsp_tlast_o,
    output rsp_tready_i,
    output host_hold_i,
    input  fifo_count_o
  );
endinterface

// File: rtl/buffering_tx.sv
// Device responses to two-beat AXI Stream packets (address, then data).
// TID-5 responses are parked in a FIFO while the host holds.
module buffering_tx #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  buffering_tx_if.slave  bus
);

  localparam int         PTR_W = $clog2(DEPTH);
  localparam logic [2:0] TID5  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;

  state_t           state_q;
  state_t           state_d;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      addr_q;
  logic [15:0]      data_q;
  logic [2:0]       tid_q;

  logic idle;
  logic is5;
  logic full;
  logic empty;
  logic drain;
  logic hold5;
  logic push;
  logic pop;
  logic cap;

  assign idle  = state_q == IDLE;
  assign is5   = bus.dev_addr_i[2:0] == TID5;
  assign full  = count_q == CNT_W'(DEPTH);
  assign empty = count_q == '0;
  assign drain = !bus.host_hold_i && !empty;
  assign hold5 = bus.dev_valid_i && is5 && bus.host_hold_i;

  // Drain wins over any new response; the device simply waits.
  assign pop  = idle && drain;
  assign push = idle && !drain && hold5 && !full;
  assign cap  = idle && !drain && bus.dev_valid_i
              && !(is5 && bus.host_hold_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop || cap) state_d = ADDR;
      ADDR: if (bus.rsp_tready_i) state_d = DATA;
      DATA: if (bus.rsp_tready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.dev_ready_o  = 1'b0;
    bus.rsp_tvalid_o = 1'b0;
    bus.rsp_tid_o    = '0;
    bus.rsp_tdata_o  = '0;
    bus.rsp_tlast_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.dev_ready_o = reset_n && !drain
                        && !(hold5 && full);
      end
      ADDR: begin
        bus.rsp_tvalid_o = 1'b1;
        bus.rsp_tid_o    = tid_q;
        bus.rsp_tdata_o  = addr_q;
      end
      DATA: begin
        bus.rsp_tvalid_o = 1'b1;
        bus.rsp_tid_o    = tid_q;
        bus.rsp_tdata_o  = data_q;
        bus.rsp_tlast_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fifo_count_o = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      tid_q  <= '0;
    end else if (pop) begin
      addr_q <= mem[rd_ptr_q].addr;
      data_q <= mem[rd_ptr_q].data;
      tid_q  <= TID5;
    end else if (cap) begin
      addr_q <= bus.dev_addr_i[18:3];
      data_q <= bus.dev_data_i;
      tid_q  <= bus.dev_addr_i[2:0];
    end
  end

  // Storage has no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{addr: bus.dev_addr_i[18:3],
                         data: bus.dev_data_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q  <= count_q + CNT_W'(1);
    end else if (pop) begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_buffering_tx.sv
// Directed-vector bench for buffering_tx.
// Per-cycle table plus hand sequences for stall, priority, reset.
module tb_buffering_tx;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic        v;
    logic [18:0] a;
    logic [15:0] d;
    logic        tr;
    logic        h;
    logic [25:0] ex;
  } vec_t;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;
  int   hs;
  vec_t tbl[$];

  buffering_tx_if #(.CNT_W(4)) bus ();

  buffering_tx #(.DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rsp_tvalid_o && bus.rsp_tready_i) hs++;
  end

  function automatic logic [25:0] e(
    input logic r, input logic tv, input logic [2:0] t,
    input logic [15:0] dd, input logic l, input logic [3:0] c);
    return {r, tv, t, dd, l, c};
  endfunction

  function automatic logic [25:0] obs();
    return {bus.dev_ready_o, bus.rsp_tvalid_o, bus.rsp_tid_o,
            bus.rsp_tdata_o, bus.rsp_tlast_o, bus.fifo_count_o};
  endfunction

  function automatic void add(
    input logic v, input logic [18:0] a, input logic [15:0] d,
    input logic tr, input logic h, input logic [25:0] ex);
    tbl.push_back('{v: v, a: a, d: d, tr: tr, h: h, ex: ex});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic v, input logic [18:0] a,
                       input logic [15:0] d, input logic tr,
                       input logic h);
    bus.dev_valid_i  = v;
    bus.dev_addr_i   = a;
    bus.dev_data_i   = d;
    bus.rsp_tready_i = tr;
    bus.host_hold_i  = h;
  endtask

  // {ready,tvalid,tid,tdata,tlast,count} checked mid-cycle.
  task automatic cyc(input string nm, input logic v,
                     input logic [18:0] a, input logic [15:0] d,
                     input logic tr, input logic h,
                     input logic [25:0] ex);
    drive(v, a, d, tr, h);
    @(negedge clk);
    chk(nm, {6'd0, obs()}, {6'd0, ex});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [25:0] z;
    logic [15:0] w;
    total   = 0;
    passed  = 0;
    hs      = 0;
    z       = '0;
    reset_n = 1'b0;
    drive(L, '0, '0, L, L);

    // pass-through
    add(H, 19'h0A5A1, 16'hBEEF, H, L, e(H, L, 3'd0, 16'h0, L, 4'd0));
    add(L, '0, '0, H, L, e(L, H, 3'd1, 16'h14B4, L, 4'd0));
    add(L, '0, '0, H, L, e(L, H, 3'd1, 16'hBEEF, H, 4'd0));
    add(L, '0, '0, H, L, e(H, L, 3'd0, 16'h0, L, 4'd0));
    // backpressure on both beats
    add(H, 19'h0A5A1, 16'hBEEF, L, L, e(H, L, 3'd0, 16'h0, L, 4'd0));
    for (int i = 0; i < 4; i++)
      add(L, '0, '0, L, L, e(L, H, 3'd1, 16'h14B4, L, 4'd0));
    add(L, '0, '0, H, L, e(L, H, 3'd1, 16'h14B4, L, 4'd0));
    for (int i = 0; i < 4; i++)
      add(L, '0, '0, L, L, e(L, H, 3'd1, 16'hBEEF, H, 4'd0));
    add(L, '0, '0, H, L, e(L, H, 3'd1, 16'hBEEF, H, 4'd0));
    add(L, '0, '0, H, L, e(H, L, 3'd0, 16'h0, L, 4'd0));
    // hold buffering then in-order drain
    add(H, 19'h0000D, 16'h1111, H, H, e(H, L, 3'd0, 16'h0, L, 4'd0));
    add(H, 19'h00015, 16'h2222, H, H, e(H, L, 3'd0, 16'h0, L, 4'd1));
    add(H, 19'h0001D, 16'h3333, H, H, e(H, L, 3'd0, 16'h0, L, 4'd2));
    add(L, '0, '0, H, H, e(H, L, 3'd0, 16'h0, L, 4'd3));
    add(L, '0, '0, H, L, e(L, L, 3'd0, 16'h0, L, 4'd3));
    add(L, '0, '0, H, L, e(L, H, 3'd5, 16'h0001, L, 4'd2));
    add(L, '0, '0, H, L, e(L, H, 3'd5, 16'h1111, H, 4'd2));
    add(L, '0, '0, H, L, e(L, L, 3'd0, 16'h0, L, 4'd2));
    add(L, '0, '0, H, L, e(L, H, 3'd5, 16'h0002, L, 4'd1));
    add(L, '0, '0, H, L, e(L, H, 3'd5, 16'h2222, H, 4'd1));
    add(L, '0, '0, H, L, e(L, L, 3'd0, 16'h0, L, 4'd1));
    add(L, '0, '0, H, L, e(L, H, 3'd5, 16'h0003, L, 4'd0));
    add(L, '0, '0, H, L, e(L, H, 3'd5, 16'h3333, H, 4'd0));
    add(L, '0, '0, H, L, e(H, L, 3'd0, 16'h0, L, 4'd0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {6'd0, obs()}, {6'd0, z});
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i])
      cyc($sformatf("vec%0d", i), tbl[i].v, tbl[i].a, tbl[i].d,
          tbl[i].tr, tbl[i].h, tbl[i].ex);
    chk("beat_count", 32'(hs), 32'd10);

    // fill to DEPTH, then stall the ninth
    for (int i = 0; i < 8; i++) begin
      w = 16'h0100 + 16'(i);
      cyc($sformatf("fill%0d", i), H, {w, 3'd5}, 16'h4000 + 16'(i),
          H, H, e(H, L, 3'd0, 16'h0, L, 4'(i)));
    end
    for (int i = 0; i < 2; i++)
      cyc("full_stall", H, {16'h0108, 3'd5}, 16'h4008, H, H,
          e(L, L, 3'd0, 16'h0, L, 4'd8));
    cyc("full_tid2_acc", H, {16'h0042, 3'd2}, 16'hA2A2, H, H,
        e(H, L, 3'd0, 16'h0, L, 4'd8));
    cyc("full_tid2_addr", L, '0, '0, H, H,
        e(L, H, 3'd2, 16'h0042, L, 4'd8));
    cyc("full_tid2_data", L, '0, '0, H, H,
        e(L, H, 3'd2, 16'hA2A2, H, 4'd8));
    for (int i = 0; i < 8; i++) begin
      w = 16'h0100 + 16'(i);
      cyc("full_drain_idle", L, '0, '0, H, L,
          e(L, L, 3'd0, 16'h0, L, 4'(8 - i)));
      cyc("full_drain_addr", L, '0, '0, H, L,
          e(L, H, 3'd5, w, L, 4'(7 - i)));
      cyc("full_drain_data", L, '0, '0, H, L,
          e(L, H, 3'd5, 16'h4000 + 16'(i), H, 4'(7 - i)));
    end
    cyc("full_done", L, '0, '0, H, L, e(H, L, 3'd0, 16'h0, L, 4'd0));

    // drain priority over a waiting TID-3 response
    cyc("pri_push0", H, {16'h0200, 3'd5}, 16'h5000, H, H,
        e(H, L, 3'd0, 16'h0, L, 4'd0));
    cyc("pri_push1", H, {16'h0201, 3'd5}, 16'h5001, H, H,
        e(H, L, 3'd0, 16'h0, L, 4'd1));
    for (int i = 0; i < 2; i++) begin
      cyc("pri_idle", H, {16'h0333, 3'd3}, 16'h3C3C, H, L,
          e(L, L, 3'd0, 16'h0, L, 4'(2 - i)));
      cyc("pri_addr", H, {16'h0333, 3'd3}, 16'h3C3C, H, L,
          e(L, H, 3'd5, 16'h0200 + 16'(i), L, 4'(1 - i)));
      cyc("pri_data", H, {16'h0333, 3'd3}, 16'h3C3C, H, L,
          e(L, H, 3'd5, 16'h5000 + 16'(i), H, 4'(1 - i)));
    end
    cyc("pri_t3_acc", H, {16'h0333, 3'd3}, 16'h3C3C, H, L,
        e(H, L, 3'd0, 16'h0, L, 4'd0));
    cyc("pri_t3_addr", L, '0, '0, H, L,
        e(L, H, 3'd3, 16'h0333, L, 4'd0));
    cyc("pri_t3_data", L, '0, '0, H, L,
        e(L, H, 3'd3, 16'h3C3C, H, 4'd0));

    // async reset in the data beat
    cyc("rst_push", H, {16'h0ABC, 3'd5}, 16'h7777, H, H,
        e(H, L, 3'd0, 16'h0, L, 4'd0));
    cyc("rst_acc", H, {16'h0777, 3'd4}, 16'h6666, L, H,
        e(H, L, 3'd0, 16'h0, L, 4'd1));
    cyc("rst_addr", L, '0, '0, H, H,
        e(L, H, 3'd4, 16'h0777, L, 4'd1));
    drive(L, '0, '0, L, H);
    @(negedge clk);
    chk("rst_data_beat", {6'd0, obs()},
        {6'd0, e(L, H, 3'd4, 16'h6666, H, 4'd1)});
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_out", {6'd0, obs()}, {6'd0, z});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_no_replay", L, '0, '0, H, L,
        e(H, L, 3'd0, 16'h0, L, 4'd0));
    cyc("post_acc", H, 19'h0A5A1, 16'h1234, H, L,
        e(H, L, 3'd0, 16'h0, L, 4'd0));
    cyc("post_addr", L, '0, '0, H, L,
        e(L, H, 3'd1, 16'h14B4, L, 4'd0));
    cyc("post_data", L, '0, '0, H, L,
        e(L, H, 3'd1, 16'h1234, H, 4'd0));
    cyc("post_idle", L, '0, '0, H, L,
        e(H, L, 3'd0, 16'h0, L, 4'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/buffering_tx.md
Name: buffering_tx

Overview:
- Return-path counterpart of the request buffering block: accepts device responses on a valid-ready interface and transmits them to the host as AXI Stream packets.
- Each device transfer becomes a two-beat packet: beat 0 carries the upper address bits, beat 1 carries the data with tlast set.
- Responses for TID 5 are parked in an internal FIFO while the host signals hold. They drain with priority once hold drops.

Parameters:
- DEPTH, 8, number of buffered TID-5 responses; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the fill-count output.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- dev_valid_i  input  1  device response valid.
- dev_addr_i  input  19  response address: [2:0] TID, [18:3] address word.
- dev_data_i  input  16  response data.
- dev_ready_o  output  1  block accepts the device response this cycle.
- rsp_tvalid_o  output  1  AXI Stream valid.
- rsp_tid_o  output  3  AXI Stream TID.
- rsp_tdata_o  output  16  AXI Stream data.
- rsp_tlast_o  output  1  high on the second (data) beat.
- rsp_tready_i  input  1  AXI Stream ready.
- host_hold_i  input  1  host status: defer TID-5 responses while high.
- fifo_count_o  output  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, FIFO empty (rd/wr pointers 0), internal addr/data/tid registers 0.
  - All outputs 0: dev_ready_o, rsp_tvalid_o, rsp_tid_o, rsp_tdata_o, rsp_tlast_o, fifo_count_o.
  - Reset mid-packet aborts the packet; no beat is replayed after reset.
- Storage: FIFO of DEPTH entries, each 32 bits = {addr[18:3], data}; TID is implicitly 5. Pointers wrap modulo DEPTH. full when count==DEPTH, empty when count==0.
- drain = !host_hold_i && !empty.
- IDLE state:
  - dev_ready_o = !drain && !(dev_valid_i && dev_addr_i[2:0]==5 && host_hold_i && full). Combinational; may depend on dev_valid_i and dev_addr_i.
  - If drain: pop the FIFO head into addr_q/data_q, set tid_q=5, go to ADDR. A device response presented this cycle is not accepted and is held by the device.
  - Else if dev_valid_i && TID==5 && host_hold_i && !full: push to FIFO, accept, stay in IDLE (one response per cycle).
  - Else if dev_valid_i && TID==5 && host_hold_i && full: ready=0, stall.
  - Else if dev_valid_i: capture addr/data/tid into registers, accept, go to ADDR. This covers any non-5 TID, and TID 5 with hold low and FIFO empty.
  - rsp_tvalid_o=0.
- ADDR state:
  - rsp_tvalid_o=1, rsp_tdata_o=addr_q[18:3], rsp_tid_o=tid_q, rsp_tlast_o=0, dev_ready_o=0.
  - On rsp_tready_i go to DATA; otherwise hold all outputs stable.
- DATA state:
  - rsp_tvalid_o=1, rsp_tdata_o=data_q, rsp_tid_o=tid_q, rsp_tlast_o=1, dev_ready_o=0.
  - On rsp_tready_i go to IDLE.
- Outputs in ADDR/DATA are driven from registers only. rsp_tvalid_o never drops before its handshake.
- host_hold_i changes during ADDR/DATA have no effect on the in-flight packet. The only effect is the IDLE decision.
- Minimum packet spacing: one IDLE cycle between packets. Throughput is 3 cycles per packet with tready held high.
- Ordering:
  - FIFO entries leave in push order.
  - With hold low, buffered entries always precede any new device response.
  - Non-5 responses may overtake buffered TID-5 responses while hold is high.
- fifo_count_o: registered; +1 on push, −1 on pop. Push and pop never occur in the same cycle.

Test Plan:
1. Pass-through with tready=1: device sends addr=0x0A5A1 (tid 1, word 0x14B4), data=0xBEEF. Expect dev_ready_o=1 for one cycle. Next cycle beat {tid=1, tdata=0x14B4, tlast=0}, then {tid=1, tdata=0xBEEF, tlast=1}.
2. Backpressure: same transfer with tready=0 for 4 cycles on each beat. Outputs stay stable and tvalid stays high; exactly two beats complete.
3. Hold buffering: with hold=1, send 3 TID-5 responses (data 0x1111, 0x2222, 0x3333). Each is accepted in 1 cycle, fifo_count_o reaches 3, and no tvalid. Drop hold: three packets emerge in order 0x1111, 0x2222, 0x3333, and fifo_count_o returns to 0.
4. Full stall: with hold=1, push DEPTH=8 entries; a 9th TID-5 response sees dev_ready_o=0. A TID-2 response during the stall is still accepted and transmitted.
5. Drain priority: fill 2 entries, drop hold while the device presents a TID-3 response. Both buffered packets transmit before the TID-3 packet, and dev_ready_o stays 0 until the FIFO is empty.
6. Async reset: assert reset_n low during the DATA beat with tready=0. All outputs go to 0 immediately and fifo_count_o=0. After release the next transfer transmits normally.
